// File: rtl/tx_pkg.sv
// tx_pkg: shared defaults, FSM state encoding and latency helper for tx_period_ctrl
package tx_pkg;

    localparam int W_DEF       = 16;
    localparam int KW_DEF      = 20;
    localparam int P_SHIFT_DEF = 3;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        TRACK    = 2'd1,
        DEADBAND = 2'd2
    } tx_state_e;

    // One capture cycle, W+KW divider iterations, one select stage, one output stage
    function automatic int tx_lat(input int w, input int kw);
        return w + kw + 3;
    endfunction

endpackage

// File: rtl/tx_seq_div.sv
// tx_seq_div: restoring divider, fixed N iterations after start; divisor 0 yields all-ones
module tx_seq_div
    import tx_pkg::*;
#(
    parameter int N  = W_DEF + KW_DEF,
    parameter int DW = W_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [N-1:0]  dividend,
    input  logic [DW-1:0] divisor,
    output logic          done,
    output logic [N-1:0]  quotient
);

    localparam int CW = $clog2(N + 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [DW-1:0] rem_q, rem_d;
    logic [N-1:0]  quo_q, quo_d;
    logic          done_q, done_d;
    logic [DW:0]   sh, diff;
    logic          ge;

    always_comb begin
        sh     = {rem_q, quo_q[N-1]};
        diff   = sh - {1'b0, divisor};
        ge     = sh >= {1'b0, divisor};
        cnt_d  = cnt_q;
        rem_d  = rem_q;
        quo_d  = quo_q;
        done_d = 1'b0;
        if (start) begin
            cnt_d = CW'(N);
            rem_d = '0;
            quo_d = dividend;
        end else if (cnt_q != '0) begin
            cnt_d  = cnt_q - CW'(1);
            rem_d  = ge ? diff[DW-1:0] : sh[DW-1:0];
            quo_d  = {quo_q[N-2:0], ge};
            done_d = cnt_q == CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            rem_q  <= '0;
            quo_q  <= '0;
            done_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            rem_q  <= rem_d;
            quo_q  <= quo_d;
            done_q <= done_d;
        end
    end

    assign done     = done_q;
    assign quotient = quo_q;

endmodule

// File: rtl/tx_period_ctrl.sv
// tx_period_ctrl: TX feeder-current FSM and fixed-latency stepper period computation
// Optional TX_SLEW_EN limits the per-update period change to slew_step.
module tx_period_ctrl
    import tx_pkg::*;
#(
    parameter int W       = W_DEF,
    parameter int KW      = KW_DEF,
    parameter int P_SHIFT = P_SHIFT_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          tx_mode,
    input  logic          data_valid,
    input  logic [W-1:0]  i_fid,
    input  logic [W-1:0]  i_set,
    input  logic [W-1:0]  dz,
    input  logic [W-1:0]  gate,
    input  logic [W-1:0]  f1,
    input  logic [W-1:0]  f2,
    input  logic [KW-1:0] k,
    input  logic [W-1:0]  l,
    input  logic [W-1:0]  slew_step,
    output logic          drv_en,
    output logic          dir,
    output logic [W-1:0]  period,
    output logic          period_valid,
    output logic          busy,
    output logic          overrun
);

    localparam int LAT = tx_lat(W, KW);
    localparam int N   = LAT - 3;
    localparam int CAPW = 6 * W + KW;

    tx_state_e      state_q, state_d;
    logic           drv_en_q, drv_en_d, dir_q, dir_d, dv_q, dv_d;
    logic           busy_q, busy_d, overrun_q, overrun_d, start_q, start_d;
    logic           tgt_v_q, tgt_v_d, pv_q, pv_d;
    logic [CAPW-1:0] cap_q, cap_d;
    logic [W-1:0]   tgt_q, tgt_d, period_q, period_d;
    logic [W-1:0]   d, dd, cd, cl, cdz, cgate, cf1, cf2, lin, nxt;
    logic [KW-1:0]  ck;
    logic [N-1:0]   prod, quo;
    logic [N:0]     sum;
    logic           lt, edge_s, accept, div_done;
`ifdef TX_SLEW_EN
    logic           up;
    logic [W-1:0]   delta, pre_q, pre_d;
`else
    logic           unused_slew;
    assign unused_slew = ^slew_step;
`endif

    assign {cd, ck, cl, cdz, cgate, cf1, cf2} = cap_q;

    always_comb begin
        lt        = i_fid < i_set;
        d         = lt ? i_set - i_fid : i_fid - i_set;
        dir_d     = lt;
        dv_d      = data_valid;
        edge_s    = data_valid & ~dv_q;
        accept    = edge_s & ~busy_q;
        state_d   = !tx_mode ? IDLE :
                    state_q == IDLE ? TRACK :
                    (state_q == TRACK && d == '0) ? DEADBAND :
                    (state_q == DEADBAND && d >= dz) ? TRACK : state_q;
        drv_en_d  = state_d == TRACK;
        busy_d    = accept | (busy_q & ~tgt_v_q);
        overrun_d = overrun_q | (edge_s & busy_q);
        cap_d     = accept ? {d, k, l, dz, gate, f1, f2} : cap_q;
        start_d   = accept;
        // Divider runs on every update so all target paths share one latency
        dd        = cd - cdz;
        prod      = N'(ck) * N'(dd);
        sum       = {1'b0, quo} + (N+1)'(cf1);
        lin       = sum > (N+1)'(cf2) ? cf2 : sum[W-1:0];
        tgt_d     = cd >= cgate ? cf2 : cd >= cdz ? lin : (cf1 > cf2 ? cf2 : cf1);
        tgt_v_d   = div_done;
        pv_d      = tgt_v_q;
`ifdef TX_SLEW_EN
        up        = tgt_q > pre_q;
        delta     = up ? tgt_q - pre_q : pre_q - tgt_q;
        nxt       = (slew_step == '0 || delta <= slew_step) ? tgt_q :
                    up ? pre_q + slew_step : pre_q - slew_step;
        pre_d     = tgt_v_q ? nxt : pre_q;
`else
        nxt       = tgt_q;
`endif
        period_d  = tgt_v_q ? nxt >> P_SHIFT : period_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            drv_en_q  <= 1'b0;
            dir_q     <= 1'b0;
            dv_q      <= 1'b0;
            busy_q    <= 1'b0;
            overrun_q <= 1'b0;
            start_q   <= 1'b0;
            tgt_v_q   <= 1'b0;
            pv_q      <= 1'b0;
            cap_q     <= '0;
            tgt_q     <= '0;
            period_q  <= '0;
`ifdef TX_SLEW_EN
            pre_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            drv_en_q  <= drv_en_d;
            dir_q     <= dir_d;
            dv_q      <= dv_d;
            busy_q    <= busy_d;
            overrun_q <= overrun_d;
            start_q   <= start_d;
            tgt_v_q   <= tgt_v_d;
            pv_q      <= pv_d;
            cap_q     <= cap_d;
            tgt_q     <= tgt_d;
            period_q  <= period_d;
`ifdef TX_SLEW_EN
            pre_q     <= pre_d;
`endif
        end
    end

    tx_seq_div #(.N(N), .DW(W)) u_div (
        .clk      (clk),
        .rst      (rst),
        .start    (start_q),
        .dividend (prod),
        .divisor  (cl),
        .done     (div_done),
        .quotient (quo)
    );

    assign drv_en       = drv_en_q;
    assign dir          = dir_q;
    assign period       = period_q;
    assign period_valid = pv_q;
    assign busy         = busy_q;
    assign overrun      = overrun_q;

endmodule

// File: tb/tb_tx_period_ctrl.sv
// tb_tx_period_ctrl: scoreboard bench for tx_period_ctrl (period value and strobe-to-output latency)
module tb_tx_period_ctrl;

    localparam int W   = 16;
    localparam int KW  = 20;
    localparam int PS  = 3;
    localparam int LAT = W + KW + 3;

    logic          clk = 0, rst = 1, tx_mode = 0, data_valid = 0;
    logic [W-1:0]  i_fid = 0, i_set = 0, dz = 0, gate = 0, f1 = 0, f2 = 0, l = 0, slew_step = 0;
    logic [KW-1:0] k = 0;
    logic          drv_en, dir, period_valid, busy, overrun;
    logic [W-1:0]  period;

    typedef struct {int p; int at;} exp_t;
    exp_t sb[$];
    exp_t e;
    int checks = 0, errors = 0, cyc = 0, pv_cnt = 0;
    longint unsigned pre = 0;

    tx_period_ctrl #(.W(W), .KW(KW), .P_SHIFT(PS)) dut (
        .clk(clk), .rst(rst), .tx_mode(tx_mode), .data_valid(data_valid),
        .i_fid(i_fid), .i_set(i_set), .dz(dz), .gate(gate), .f1(f1), .f2(f2),
        .k(k), .l(l), .slew_step(slew_step), .drv_en(drv_en), .dir(dir),
        .period(period), .period_valid(period_valid), .busy(busy), .overrun(overrun)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (period_valid) begin
            pv_cnt++;
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_pv period=%0d required no pulse at cycle %0d", period, cyc);
            end else begin
                e = sb.pop_front();
                if (int'(period) != e.p) begin
                    errors++;
                    $display("FAIL period got=%0d exp=%0d", period, e.p);
                end
                checks++;
                if (cyc != e.at) begin
                    errors++;
                    $display("FAIL latency got_cycle=%0d exp_cycle=%0d", cyc, e.at);
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    function automatic longint unsigned model(input longint unsigned di, dzi, gi, ki, li, f1i, f2i);
        longint unsigned q, s;
        if (di >= gi) return f2i;
        if (di < dzi) return f1i > f2i ? f2i : f1i;
        q = (li == 0) ? (64'd1 << (W + KW)) - 1 : (ki * (di - dzi)) / li;
        s = q + f1i;
        return s > f2i ? f2i : s;
    endfunction

    task automatic strobe(input bit sync);
        longint unsigned d, t;
        d = (i_fid < i_set) ? i_set - i_fid : i_fid - i_set;
        t = model(d, dz, gate, k, l, f1, f2);
`ifdef TX_SLEW_EN
        if (slew_step == 0 || (t > pre ? t - pre : pre - t) <= slew_step) pre = t;
        else pre = (t > pre) ? pre + slew_step : pre - slew_step;
`else
        pre = t;
`endif
        if (sync) begin
            @(posedge clk); #1;
        end
        data_valid = 1;
        sb.push_back(exp_t'{int'(pre >> PS), cyc + 1 + LAT});
        @(posedge clk); #1;
        data_valid = 0;
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while (sb.size() != 0 && n < 4 * LAT) begin
            @(posedge clk);
            n++;
        end
        @(posedge clk); #1;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL %s drain_timeout pending=%0d required 0", name, sb.size());
            sb.delete();
        end
    endtask

    task automatic set_linear();
        i_set = 1000; i_fid = 900; dz = 10; gate = 500; k = 64; l = 8; f1 = 100; f2 = 4000;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({drv_en, dir, period_valid, busy, overrun} !== 5'b0) begin
            errors++;
            $display("FAIL reset_flags got=%b exp=00000", {drv_en, dir, period_valid, busy, overrun});
        end
        checks++;
        if (period !== '0) begin
            errors++;
            $display("FAIL reset_period got=%0d exp=0", period);
        end
        rst = 0;
    endtask

    task automatic test_linear();
        set_linear();
        strobe(1);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL linear_busy got=%b exp=1", busy);
        end
        checks++;
        if (dir !== 1'b1) begin
            errors++;
            $display("FAIL linear_dir got=%b exp=1", dir);
        end
        wait_drain("linear");
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL linear_busy_clear got=%b exp=0", busy);
        end
    endtask

    task automatic test_saturation();
        set_linear();
        i_fid = 2000;
        strobe(1);
        checks++;
        if (dir !== 1'b0) begin
            errors++;
            $display("FAIL sat_dir got=%b exp=0", dir);
        end
        wait_drain("sat_gate");
        i_fid = 900; l = 0;
        strobe(1);
        wait_drain("sat_l0");
        i_fid = 1000; f1 = 300; f2 = 200;
        strobe(1);
        wait_drain("f1_gt_f2");
    endtask

    task automatic test_patterns();
        for (int i = 0; i < 6; i++) begin
            i_set = W'($urandom_range(0, 5000));
            i_fid = W'($urandom_range(0, 5000));
            dz    = W'($urandom_range(0, 200));
            gate  = W'($urandom_range(100, 3000));
            k     = KW'($urandom_range(0, 5000));
            l     = W'($urandom_range(0, 50));
            f1    = W'($urandom_range(0, 1000));
            f2    = W'($urandom_range(0, 8000));
            strobe(1);
            wait_drain("pattern");
        end
    endtask

    task automatic test_fsm();
        set_linear();
        @(posedge clk); #1;
        checks++;
        if (drv_en !== 1'b0) begin
            errors++;
            $display("FAIL fsm_idle got=%b exp=0", drv_en);
        end
        tx_mode = 1;
        @(posedge clk); #1;
        checks++;
        if (drv_en !== 1'b1) begin
            errors++;
            $display("FAIL fsm_track got=%b exp=1", drv_en);
        end
        i_fid = 1000;
        @(posedge clk); #1;
        checks++;
        if (drv_en !== 1'b0) begin
            errors++;
            $display("FAIL fsm_deadband got=%b exp=0", drv_en);
        end
        i_fid = 995;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (drv_en !== 1'b0) begin
            errors++;
            $display("FAIL fsm_in_dz got=%b exp=0", drv_en);
        end
        i_fid = 1010;
        @(posedge clk); #1;
        checks++;
        if (drv_en !== 1'b1 || dir !== 1'b0) begin
            errors++;
            $display("FAIL fsm_retrack drv_en=%b dir=%b exp 1 0", drv_en, dir);
        end
        tx_mode = 0;
        @(posedge clk); #1;
        checks++;
        if (drv_en !== 1'b0) begin
            errors++;
            $display("FAIL fsm_drop got=%b exp=0", drv_en);
        end
    endtask

    task automatic test_back_to_back();
        int n = 0;
        set_linear();
        strobe(1);
        @(negedge clk);
        while (!period_valid && n < 2 * LAT) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!period_valid || busy !== 1'b0) begin
            errors++;
            $display("FAIL b2b_pv_cycle pv=%b busy=%b exp 1 0", period_valid, busy);
        end
        i_fid = 2000;
        strobe(0);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL b2b_accept busy=%b exp=1", busy);
        end
        wait_drain("b2b");
    endtask

    task automatic test_overrun();
        int p0;
        set_linear();
        i_fid = 700;
        strobe(1);
        repeat (LAT / 2 - 2) @(posedge clk);
        #1;
        data_valid = 1;
        @(posedge clk); #1;
        data_valid = 0;
        checks++;
        if (overrun !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL overrun_set overrun=%b busy=%b exp 1 1", overrun, busy);
        end
        p0 = pv_cnt;
        wait_drain("overrun");
        repeat (LAT) @(posedge clk);
        #1;
        checks++;
        if (pv_cnt != p0 + 1 || overrun !== 1'b1) begin
            errors++;
            $display("FAIL overrun_single pulses=%0d exp=1 overrun=%b exp=1", pv_cnt - p0, overrun);
        end
    endtask

    task automatic test_reset_mid();
        int p0;
        set_linear();
        tx_mode = 1;
        strobe(1);
        repeat (10) @(posedge clk);
        #1;
        rst = 1;
        @(posedge clk); #1;
        checks++;
        if ({drv_en, dir, period_valid, busy, overrun} !== 5'b0 || period !== '0) begin
            errors++;
            $display("FAIL mid_reset flags=%b period=%0d exp 00000 0", {drv_en, dir, period_valid, busy, overrun}, period);
        end
        sb.delete();
        pre = 0;
        tx_mode = 0;
        rst = 0;
        p0 = pv_cnt;
        repeat (LAT + 10) @(posedge clk);
        #1;
        checks++;
        if (pv_cnt != p0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_discard pulses=%0d busy=%b exp 0 0", pv_cnt - p0, busy);
        end
    endtask

`ifdef TX_SLEW_EN
    task automatic test_slew();
        set_linear();
        slew_step = 40;
        strobe(1);
        wait_drain("slew_first");
        checks++;
        if (period !== 16'd5) begin
            errors++;
            $display("FAIL slew_first got=%0d exp=5", period);
        end
        i_fid = 2000;
        for (int i = 0; i < 4; i++) begin
            strobe(1);
            wait_drain("slew_step");
        end
        slew_step = 0;
        strobe(1);
        wait_drain("slew_unlimited");
    endtask
`endif

    initial begin
        test_reset();
        test_linear();
        test_saturation();
        test_patterns();
        test_fsm();
        test_back_to_back();
        test_overrun();
        test_reset_mid();
`ifdef TX_SLEW_EN
        test_slew();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
